// File: rtl/counter_ctrl.sv
// Round-robin countdown controller driving an external load/decrement counter IP.
// Optional abort support (input abort, output req_err) is enabled by defining COUNTER_CTRL_ABORT_EN.
module counter_ctrl #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_len0,
    input  logic [7:0] req_len1,
    input  logic [1:0] req_div,
    output logic [1:0] req_ready,
    output logic [1:0] req_done,
    output logic       busy,
    output logic [7:0] cnt_in,
    output logic       cnt_latch,
    output logic       cnt_dec,
    output logic       cnt_div,
    input  logic [7:0] cnt_count,
    input  logic       cnt_zero
`ifdef COUNTER_CTRL_ABORT_EN
    ,
    input  logic       abort,
    output logic       req_err
`endif
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e        state_q;
    logic          ptr_q;
    logic          owner_q;
    logic [CW-1:0] rem_q;
    logic [CW-1:0] presc_q;

    logic [1:0]    grant_c;
    logic [CW-1:0] presc_nxt_c;
    logic [CW-1:0] presc_tgt_c;
    logic          dec_c;
    logic          abort_c;
    logic          abort_hit_c;
    logic          run_end_c;
    logic          to_done_c;

    // The count value is observed only; folding it keeps the port without a dangling net.
    logic unused_cnt_count;
    assign unused_cnt_count = ^cnt_count;

`ifdef COUNTER_CTRL_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Grant: a lone requester wins; on a tie the pointer picks the one not served last.
    always_comb begin
        grant_c = req_valid;
        if (req_valid == 2'b11) begin
            grant_c = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // rem_q tracks decrements still to issue, so back-to-back pulses never overshoot zero.
    always_comb begin
        presc_nxt_c = (presc_q == PRESC_MAX) ? '0 : presc_q + CW'(1);
        presc_tgt_c = (state_q == S_SETTLE) ? '0 : presc_nxt_c;
        dec_c       = (presc_tgt_c == PRESC_MAX) && (rem_q != '0) && !cnt_zero;
        abort_hit_c = abort_c && ((state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_RUN));
        run_end_c   = (state_q == S_RUN) && cnt_zero && !cnt_dec;
        to_done_c   = abort_hit_c || run_end_c;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            rem_q     <= '0;
            presc_q   <= '0;
            req_ready <= '0;
            req_done  <= '0;
            busy      <= 1'b0;
            cnt_in    <= '0;
            cnt_latch <= 1'b0;
            cnt_dec   <= 1'b0;
            cnt_div   <= 1'b0;
`ifdef COUNTER_CTRL_ABORT_EN
            req_err   <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            cnt_latch <= 1'b0;
            cnt_dec   <= 1'b0;
`ifdef COUNTER_CTRL_ABORT_EN
            req_err   <= abort_hit_c;
`endif
            if (to_done_c) begin
                state_q  <= S_DONE;
                req_done <= owner_q ? 2'b10 : 2'b01;
                ptr_q    <= ~owner_q;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req_ready != 2'b00) begin
                            if ((req_valid & req_ready) != 2'b00) begin
                                owner_q   <= req_ready[1];
                                cnt_in    <= req_ready[1] ? req_len1 : req_len0;
                                rem_q     <= req_ready[1] ? req_len1 : req_len0;
                                cnt_div   <= req_ready[1] ? req_div[1] : req_div[0];
                                cnt_latch <= 1'b1;
                                busy      <= 1'b1;
                                state_q   <= S_LOAD;
                            end
                        end else begin
                            req_ready <= grant_c;
                        end
                    end
                    S_LOAD: begin
                        state_q <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        state_q <= S_RUN;
                        presc_q <= '0;
                        if (dec_c) begin
                            cnt_dec <= 1'b1;
                            rem_q   <= rem_q - CW'(1);
                        end
                    end
                    S_RUN: begin
                        presc_q <= presc_nxt_c;
                        if (dec_c) begin
                            cnt_dec <= 1'b1;
                            rem_q   <= rem_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4: clock cycles between successive decrement pulses; legal range 1..255.
REQ-002 clk_clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset_reset_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  2  per-requester countdown request.
REQ-005 req_len0 / req_len1  in  8 each  countdown length for requester 0 / 1.
REQ-006 req_div  in  2  per-requester divide-mode bit.
REQ-007 req_ready  out  2  one-hot accept strobe.
REQ-008 req_done  out  2  one-hot completion strobe.
REQ-009 busy  out  1  high whenever not IDLE.
REQ-010 cnt_in  out  8  load value to counter IP.
REQ-011 cnt_latch  out  1  load strobe to counter IP.
REQ-012 cnt_dec  out  1  decrement strobe to counter IP.
REQ-013 cnt_div  out  1  divide-mode select to counter IP.
REQ-014 cnt_count  in  8  counter IP value, monitor only.
REQ-015 cnt_zero  in  1  counter IP zero flag.

Function
REQ-016 Counter IP contract: cnt_latch at edge k gives count=cnt_in after edge k; one cnt_dec gives count-1 after the next edge; cnt_zero is combinational (count==0).
REQ-017 FSM states: IDLE, LOAD, SETTLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: a request transfers when req_valid[i] and req_ready[i] are high in the same cycle; req_ready is a one-cycle pulse for the granted requester only.
REQ-019 Arbitration is round-robin: the requester not served last wins a tie; priority pointer resets to requester 0.
REQ-020 On accept: owner, length and req_div[owner] are captured; cnt_in and cnt_div hold the captured values until the next accept.
REQ-021 LOAD lasts one cycle with cnt_latch=1, then goes to SETTLE; SETTLE lasts one cycle, then goes to RUN.
REQ-022 RUN: prescaler clears on entry and wraps at TICK_DIV-1; cnt_dec=1 for one cycle when prescaler==TICK_DIV-1 and cnt_zero=0.
REQ-023 cnt_dec is never asserted while cnt_zero=1, so the counter never underflows below 0.
REQ-024 RUN goes to DONE when cnt_zero=1 in a cycle with no cnt_dec asserted.
REQ-025 Length 0 produces no cnt_dec pulses and goes to DONE directly from the first RUN cycle.
REQ-026 DONE lasts one cycle: req_done[owner]=1, priority pointer advances, state returns to IDLE.
REQ-027 Latency with accept at cycle 0: first cnt_dec at cycle TICK_DIV+2, nth at cycle n*TICK_DIV+2, req_done at cycle 4+N*TICK_DIV.
REQ-028 req_valid dropping after accept has no effect on the operation in progress; no request is accepted outside IDLE.

Reset
REQ-029 With reset_reset_n=0 at an edge: state=IDLE, pointer=0, and every output is 0 (including cnt_in, cnt_div, req_ready, req_done, busy) after that edge, regardless of the current state.
REQ-030 A reset during RUN discards the operation with no req_done; a new accept is possible on the first cycle after reset is released.

Configuration
REQ-031 Macro COUNTER_CTRL_ABORT_EN defined: adds input abort (1 bit) and output req_err (1 bit, reset 0).
REQ-032 With the macro defined, abort=1 in LOAD, SETTLE or RUN forces DONE on the next edge, with no further cnt_dec, and req_err=1 alongside req_done; abort in IDLE or DONE is ignored.
REQ-033 With the macro undefined, the abort and req_err ports do not exist and operations always run to zero.

Verification
REQ-034 TICK_DIV=4, req0 len=3 accepted at cycle 0 -> cnt_latch at 1, cnt_in=3, cnt_dec at 6/10/14, req_done=01 at 16.
REQ-035 req1 len=0 -> req_ready=10, no cnt_dec, req_done=10 at cycle 4, busy cycles 1-4.
REQ-036 req_valid=11 held after reset -> service order 0,1,0,1; each req_ready a single-cycle one-hot pulse.
REQ-037 reset_reset_n=0 for one cycle mid-RUN (req0 len=5) -> all outputs 0 next cycle, no req_done, new request accepted.
REQ-038 COUNTER_CTRL_ABORT_EN set, abort in RUN after 2 decs -> next cycle req_done=01 and req_err=1, no further cnt_dec.
REQ-039 len=255, TICK_DIV=1 -> 255 cnt_dec pulses, none while cnt_zero=1, req_done at cycle 259.
